// File: rtl/axis_seq_check.sv
// axis_seq_check: AXI-Stream sequence-continuity checker.
// Forwards the stream through a 2-entry skid buffer. All outputs are registered.
// Each accepted beat's tuser is compared with the previous accepted tuser + 1,
// modulo 2^USER_WIDTH. Discontinuities are flagged on m_tgap and counted in a
// saturating error counter.
// Optional build macro AXIS_SEQ_CHECK_DROP_EN: when it is defined, a mismatching
// beat is consumed but not forwarded, and the gap flag moves to the next
// forwarded beat.
module axis_seq_check #(
    parameter int DATA_WIDTH  = 8,
    parameter int USER_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [DATA_WIDTH-1:0]  s_tdata,
    input  logic [USER_WIDTH-1:0]  s_tuser,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [DATA_WIDTH-1:0]  m_tdata,
    output logic [USER_WIDTH-1:0]  m_tuser,
    output logic                   m_tgap,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   locked,
    output logic [COUNT_WIDTH-1:0] error_count
);

    localparam logic [USER_WIDTH-1:0]  USER_ONE  = {{(USER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t                 state_r, state_next_s;
    logic [USER_WIDTH-1:0]  expected_r, expected_next_s;
    logic                   locked_r, locked_next_s;
    logic [COUNT_WIDTH-1:0] error_count_r, error_count_next_s;
    logic                   accept_s;
    logic                   mismatch_s;
    logic                   push_s;
    logic                   beat_gap_s;
    logic                   out_free_s;

    // Output register (entry 0) and skid register (entry 1).
    logic                   m_tvalid_r, m_tvalid_next_s;
    logic [DATA_WIDTH-1:0]  m_tdata_r, m_tdata_next_s;
    logic [USER_WIDTH-1:0]  m_tuser_r, m_tuser_next_s;
    logic                   m_tgap_r, m_tgap_next_s;
    logic                   skid_valid_r, skid_valid_next_s;
    logic [DATA_WIDTH-1:0]  skid_tdata_r, skid_tdata_next_s;
    logic [USER_WIDTH-1:0]  skid_tuser_r, skid_tuser_next_s;
    logic                   skid_tgap_r, skid_tgap_next_s;
    logic                   s_tready_r, s_tready_next_s;

`ifdef AXIS_SEQ_CHECK_DROP_EN
    logic                   pend_gap_r, pend_gap_next_s;
`endif

    assign accept_s = s_tvalid && s_tready_r;

    // Sequence FSM: lock on the first beat, then track the expected tuser and count mismatches.
    always_comb begin
        state_next_s       = state_r;
        expected_next_s    = expected_r;
        locked_next_s      = locked_r;
        error_count_next_s = error_count_r;
        mismatch_s         = 1'b0;
        if (accept_s) begin
            case (state_r)
                ST_UNLOCKED: begin
                    state_next_s    = ST_LOCKED;
                    expected_next_s = s_tuser + USER_ONE;
                    locked_next_s   = 1'b1;
                end
                ST_LOCKED: begin
                    if (s_tuser == expected_r) begin
                        expected_next_s = expected_r + USER_ONE;
                    end else begin
                        mismatch_s      = 1'b1;
                        expected_next_s = s_tuser + USER_ONE;
                        if (error_count_r != COUNT_MAX) begin
                            error_count_next_s = error_count_r + COUNT_ONE;
                        end else begin
                            error_count_next_s = error_count_r;
                        end
                    end
                end
                default: begin
                    state_next_s  = ST_UNLOCKED;
                    locked_next_s = 1'b0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

`ifdef AXIS_SEQ_CHECK_DROP_EN
    // Drop mode: mismatching beats are swallowed and the gap is carried to the next forwarded beat.
    always_comb begin
        push_s          = accept_s && !mismatch_s;
        beat_gap_s      = pend_gap_r;
        pend_gap_next_s = pend_gap_r;
        if (accept_s && mismatch_s) begin
            pend_gap_next_s = 1'b1;
        end else if (accept_s) begin
            pend_gap_next_s = 1'b0;
        end else begin
            pend_gap_next_s = pend_gap_r;
        end
    end
`else
    // Forward mode: every accepted beat is forwarded, marked when it broke the sequence.
    always_comb begin
        push_s     = accept_s;
        beat_gap_s = mismatch_s;
    end
`endif

    assign out_free_s = !m_tvalid_r || m_tready;

    // Skid buffer steering: refill the output from the skid entry first, otherwise from the input.
    always_comb begin
        m_tvalid_next_s   = m_tvalid_r;
        m_tdata_next_s    = m_tdata_r;
        m_tuser_next_s    = m_tuser_r;
        m_tgap_next_s     = m_tgap_r;
        skid_valid_next_s = skid_valid_r;
        skid_tdata_next_s = skid_tdata_r;
        skid_tuser_next_s = skid_tuser_r;
        skid_tgap_next_s  = skid_tgap_r;
        if (out_free_s) begin
            if (skid_valid_r) begin
                m_tvalid_next_s   = 1'b1;
                m_tdata_next_s    = skid_tdata_r;
                m_tuser_next_s    = skid_tuser_r;
                m_tgap_next_s     = skid_tgap_r;
                skid_valid_next_s = 1'b0;
            end else if (push_s) begin
                m_tvalid_next_s = 1'b1;
                m_tdata_next_s  = s_tdata;
                m_tuser_next_s  = s_tuser;
                m_tgap_next_s   = beat_gap_s;
            end else begin
                m_tvalid_next_s = 1'b0;
            end
        end else begin
            if (push_s) begin
                skid_valid_next_s = 1'b1;
                skid_tdata_next_s = s_tdata;
                skid_tuser_next_s = s_tuser;
                skid_tgap_next_s  = beat_gap_s;
            end else begin
                skid_valid_next_s = skid_valid_r;
            end
        end
        s_tready_next_s = !skid_valid_next_s;
    end

    // Sequence state registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_UNLOCKED;
            expected_r    <= '0;
            locked_r      <= 1'b0;
            error_count_r <= '0;
        end else begin
            state_r       <= state_next_s;
            expected_r    <= expected_next_s;
            locked_r      <= locked_next_s;
            error_count_r <= error_count_next_s;
        end
    end

`ifdef AXIS_SEQ_CHECK_DROP_EN
    // Pending-gap flag for dropped beats.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend_gap_r <= 1'b0;
        end else begin
            pend_gap_r <= pend_gap_next_s;
        end
    end
`endif

    // Skid buffer and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_tvalid_r   <= 1'b0;
            m_tdata_r    <= '0;
            m_tuser_r    <= '0;
            m_tgap_r     <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_tdata_r <= '0;
            skid_tuser_r <= '0;
            skid_tgap_r  <= 1'b0;
            s_tready_r   <= 1'b0;
        end else begin
            m_tvalid_r   <= m_tvalid_next_s;
            m_tdata_r    <= m_tdata_next_s;
            m_tuser_r    <= m_tuser_next_s;
            m_tgap_r     <= m_tgap_next_s;
            skid_valid_r <= skid_valid_next_s;
            skid_tdata_r <= skid_tdata_next_s;
            skid_tuser_r <= skid_tuser_next_s;
            skid_tgap_r  <= skid_tgap_next_s;
            s_tready_r   <= s_tready_next_s;
        end
    end

    assign s_tready    = s_tready_r;
    assign m_tvalid    = m_tvalid_r;
    assign m_tdata     = m_tdata_r;
    assign m_tuser     = m_tuser_r;
    assign m_tgap      = m_tgap_r;
    assign locked      = locked_r;
    assign error_count = error_count_r;

endmodule

// File: tb/tb_axis_seq_check.sv
// Directed testbench for axis_seq_check (default widths plus a COUNT_WIDTH=2 instance).
module tb_axis_seq_check;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] u;
        logic       g;
    } beat_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic [7:0]  s_tdata = 8'd0;
    logic [7:0]  s_tuser = 8'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic [7:0]  m_tuser;
    logic        m_tgap;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        locked;
    logic [15:0] error_count;

    logic [7:0]  s2_tuser = 8'd0;
    logic        s2_tvalid = 1'b0;
    logic        s2_tready;
    logic [7:0]  m2_tdata;
    logic [7:0]  m2_tuser;
    logic        m2_tgap;
    logic        m2_tvalid;
    logic        locked2;
    logic [1:0]  error_count2;

    int tests = 0;
    int fails = 0;

    beat_t      exp_q[$];
    bit         mdl_locked = 1'b0;
    logic [7:0] mdl_exp = 8'd0;
    bit         mdl_pend = 1'b0;

    bit         prev_stall = 1'b0;
    beat_t      prev_out;
    bit         prev_acc = 1'b0;
    logic [7:0] prev_acc_u = 8'd0;
    bit         lat_chk = 1'b0;
    bit         thr_chk = 1'b0;
    int         out_cnt = 0;
    int         gap_cnt = 0;
    logic [7:0] gap_user = 8'd0;

    axis_seq_check #(.DATA_WIDTH(8), .USER_WIDTH(8), .COUNT_WIDTH(16)) dut (
        .clock(clock), .resetn(resetn),
        .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tgap(m_tgap), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .locked(locked), .error_count(error_count)
    );

    axis_seq_check #(.DATA_WIDTH(8), .USER_WIDTH(8), .COUNT_WIDTH(2)) dut2 (
        .clock(clock), .resetn(resetn),
        .s_tdata(8'h00), .s_tuser(s2_tuser), .s_tvalid(s2_tvalid), .s_tready(s2_tready),
        .m_tdata(m2_tdata), .m_tuser(m2_tuser), .m_tgap(m2_tgap), .m_tvalid(m2_tvalid),
        .m_tready(1'b1), .locked(locked2), .error_count(error_count2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of one accepted beat.
    task automatic model_accept(input logic [7:0] d, input logic [7:0] u);
        beat_t b;
        b.d = d;
        b.u = u;
        b.g = 1'b0;
        if (!mdl_locked) begin
            mdl_locked = 1'b1;
            mdl_exp = u + 8'd1;
            b.g = mdl_pend;
            mdl_pend = 1'b0;
            exp_q.push_back(b);
        end else if (u == mdl_exp) begin
            mdl_exp = mdl_exp + 8'd1;
            b.g = mdl_pend;
            mdl_pend = 1'b0;
            exp_q.push_back(b);
        end else begin
            mdl_exp = u + 8'd1;
`ifdef AXIS_SEQ_CHECK_DROP_EN
            mdl_pend = 1'b1;
`else
            b.g = 1'b1;
            exp_q.push_back(b);
`endif
        end
    endtask

    // One clock: observe at the negedge, then return just after the next posedge.
    task automatic step(output bit acc);
        beat_t b;
        @(negedge clock);
        if (prev_stall) begin
            check("stall_valid", {31'd0, m_tvalid}, 32'd1);
            check("stall_hold", {15'd0, m_tdata, m_tuser, m_tgap}, {15'd0, prev_out});
        end
        if (lat_chk && prev_acc) check("latency", {23'd0, m_tvalid, m_tuser}, {23'd0, 1'b1, prev_acc_u});
        if (thr_chk) check("tready_high", {31'd0, s_tready}, 32'd1);
        if (m_tvalid && m_tready) begin
            out_cnt++;
            if (m_tgap) begin
                gap_cnt++;
                gap_user = m_tuser;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {24'd0, m_tuser}, 32'h100);
            end else begin
                b = exp_q.pop_front();
                check("beat", {15'd0, m_tdata, m_tuser, m_tgap}, {15'd0, b});
            end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_out = {m_tdata, m_tuser, m_tgap};
        acc = s_tvalid && s_tready;
        if (acc) model_accept(s_tdata, s_tuser);
        prev_acc = acc;
        prev_acc_u = s_tuser;
        @(posedge clock);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] u, input bit rnd);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        s_tvalid = 1'b1;
        s_tuser = u;
        s_tdata = u ^ 8'h5A;
        while (!acc && guard < 50) begin
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step(acc);
            guard++;
        end
        if (!acc) check("accept_timeout", {31'd0, s_tready}, 32'd1);
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        s_tvalid = 1'b0;
        s2_tvalid = 1'b0;
        #1;
        check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_s_tready", {31'd0, s_tready}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_error_count", {16'd0, error_count}, 32'd0);
        check("rst_out_regs", {15'd0, m_tdata, m_tuser, m_tgap}, 32'd0);
        exp_q.delete();
        mdl_locked = 1'b0;
        mdl_exp = 8'd0;
        mdl_pend = 1'b0;
        prev_stall = 1'b0;
        prev_acc = 1'b0;
        out_cnt = 0;
        gap_cnt = 0;
        gap_user = 8'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_s_tready_hold", {31'd0, s_tready}, 32'd0);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check("s_tready_after_rst", {31'd0, s_tready}, 32'd1);
    endtask

    task automatic send2(input logic [7:0] u);
        bit got;
        got = 1'b0;
        s2_tuser = u;
        s2_tvalid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = s2_tready;
            @(posedge clock);
            #1;
        end
        if (!got) check("dut2_accept", {31'd0, s2_tready}, 32'd1);
        s2_tvalid = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();

        // Straight count 0..9 at full rate.
        lat_chk = 1'b1;
        thr_chk = 1'b1;
        send_beat(8'd0, 1'b0);
        check("locked_after_first", {31'd0, locked}, 32'd1);
        for (int i = 1; i < 10; i++) send_beat(8'(i), 1'b0);
        idle(3);
        check("t1_error_count", {16'd0, error_count}, 32'd0);
        check("t1_out_cnt", 32'(out_cnt), 32'd10);
        check("t1_gap_cnt", 32'(gap_cnt), 32'd0);
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // Wrap from 0xFE to 0x01 is continuous.
        do_reset();
        send_beat(8'hFE, 1'b0);
        send_beat(8'hFF, 1'b0);
        send_beat(8'h00, 1'b0);
        send_beat(8'h01, 1'b0);
        idle(3);
        check("t2_error_count", {16'd0, error_count}, 32'd0);
        check("t2_gap_cnt", 32'(gap_cnt), 32'd0);
        check("t2_out_cnt", 32'(out_cnt), 32'd4);

        // 5,6,8,9: one discontinuity at 8.
        do_reset();
        lat_chk = 1'b0;
        send_beat(8'd5, 1'b0);
        send_beat(8'd6, 1'b0);
        send_beat(8'd8, 1'b0);
        check("t3_error_count_next", {16'd0, error_count}, 32'd1);
        send_beat(8'd9, 1'b0);
        idle(3);
        check("t3_error_count", {16'd0, error_count}, 32'd1);
        check("t3_gap_cnt", 32'(gap_cnt), 32'd1);
`ifdef AXIS_SEQ_CHECK_DROP_EN
        check("t3_out_cnt", 32'(out_cnt), 32'd3);
        check("t3_gap_user", {24'd0, gap_user}, 32'd9);
`else
        check("t3_out_cnt", 32'(out_cnt), 32'd4);
        check("t3_gap_user", {24'd0, gap_user}, 32'd8);
`endif

        // Random backpressure over a full 0..255 sweep.
        do_reset();
        thr_chk = 1'b0;
        for (int i = 0; i < 256; i++) send_beat(8'(i), 1'b1);
        idle(8);
        check("t4_error_count", {16'd0, error_count}, 32'd0);
        check("t4_out_cnt", 32'(out_cnt), 32'd256);
        check("t4_gap_cnt", 32'(gap_cnt), 32'd0);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Saturating counter on the 2-bit instance: lock, then five mismatches.
        send2(8'd0);
        send2(8'd5);
        send2(8'd10);
        check("t5_count_two", {30'd0, error_count2}, 32'd2);
        send2(8'd15);
        send2(8'd20);
        send2(8'd25);
        repeat (2) @(posedge clock);
        #1;
        check("t5_count_sat", {30'd0, error_count2}, 32'd3);
        check("t5_locked2", {31'd0, locked2}, 32'd1);

        // Mid-stream reset after tuser 40, then resume at 100.
        do_reset();
        thr_chk = 1'b1;
        for (int i = 0; i <= 20; i++) send_beat(8'(i), 1'b0);
        for (int i = 25; i <= 40; i++) send_beat(8'(i), 1'b0);
        check("t6_error_before", {16'd0, error_count}, 32'd1);
        check("t6_inflight_valid", {31'd0, m_tvalid}, 32'd1);
        do_reset();
        lat_chk = 1'b1;
        for (int i = 100; i <= 110; i++) send_beat(8'(i), 1'b0);
        check("t6_relocked", {31'd0, locked}, 32'd1);
        idle(3);
        check("t6_error_after", {16'd0, error_count}, 32'd0);
        check("t6_out_cnt", 32'(out_cnt), 32'd11);
        check("t6_gap_cnt", 32'(gap_cnt), 32'd0);
        check("t6_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_seq_check.md
Name: axis_seq_check

Overview:
- Consumes an AXI-Stream whose tuser carries a free-running beat counter, as produced by the counter-tagged copy stage, and forwards it unchanged with registered outputs.
- Checks every accepted beat for sequence continuity: tuser must equal the previous accepted tuser + 1, modulo 2^USER_WIDTH.
- Flags and counts discontinuities; used downstream of a tagged source to detect lost or duplicated beats.

Parameters:
- DATA_WIDTH, 8, width of tdata.
- USER_WIDTH, 8, width of the tuser sequence counter.
- COUNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clock  input  1  single clock; all logic rising-edge.
- resetn  input  1  asynchronous, active-low reset.
- s_tdata  input  DATA_WIDTH  input data.
- s_tuser  input  USER_WIDTH  input sequence number.
- s_tvalid  input  1  input valid.
- s_tready  output  1  input ready.
- m_tdata  output  DATA_WIDTH  forwarded data.
- m_tuser  output  USER_WIDTH  forwarded sequence number.
- m_tgap  output  1  high on the output beat that follows a discontinuity.
- m_tvalid  output  1  output valid.
- m_tready  input  1  output ready.
- locked  output  1  high once the first beat after reset has been accepted.
- error_count  output  COUNT_WIDTH  number of discontinuities, saturating.

Behaviour:
- Reset (resetn low, asynchronous): m_tvalid=0, s_tready=0 while asserted, m_tdata/m_tuser/m_tgap=0, locked=0, error_count=0, expected=0, state UNLOCKED, skid buffer empty.
- s_tready goes to 1 on the first clock edge after resetn deasserts, then follows skid-buffer state.
- Datapath: 2-entry skid buffer; all outputs registered; no combinational path from m_tready to s_tready.
  - Latency: 1 cycle from accept to m_tvalid.
  - Sustains 1 beat/cycle when m_tready is held high.
- Skid buffer handshake:
  - Accept = s_tvalid && s_tready.
  - s_tready=0 only when both entries are full.
  - m_tvalid, m_tdata, m_tuser and m_tgap stay stable while m_tvalid && !m_tready.
- FSM (advances on accepted beats only):
  - UNLOCKED: first accepted beat → m_tgap=0 for that beat; expected ← s_tuser+1; locked ← 1; go to LOCKED.
  - LOCKED, match (s_tuser == expected) → m_tgap=0; expected ← expected+1.
  - LOCKED, mismatch → m_tgap=1 for that beat; expected ← s_tuser+1 (resync); error_count ← error_count+1 unless already at all-ones.
- Arithmetic: expected wraps modulo 2^USER_WIDTH, so 0xFF followed by 0x00 is continuous for USER_WIDTH=8. error_count saturates at 2^COUNT_WIDTH−1.
- Gap detection is evaluated at accept time. Backpressure and stalls never create gaps; idle cycles are ignored.
- error_count and locked update the cycle after the offending beat is accepted, regardless of m_tready.
- Mid-operation reset: in-flight beats are discarded; the first beat after reset relocks without counting an error.

Optional Feature:
- Macro: AXIS_SEQ_CHECK_DROP_EN.
- Defined: a mismatching beat in LOCKED is consumed (s_tready honoured) but not written to the skid buffer.
  - Counter and expected still update as above.
  - m_tgap is then set on the next forwarded beat instead.
- Undefined: all beats are forwarded; m_tgap marks the mismatching beat itself.

Test Plan:
- Stream tuser 0..9 with m_tready=1 → identical output 1 cycle later, m_tgap always 0, error_count=0, locked=1 after first beat.
- tuser 0xFE,0xFF,0x00,0x01 → wrap accepted, no gap, error_count=0.
- tuser 5,6,8,9 → beat 8 has m_tgap=1, error_count=1, beat 9 gap-free. With DROP_EN: beat 8 absent and beat 9 has m_tgap=1.
- Random m_tready (50%) with continuous input tuser 0..255 → no lost, duplicated or reordered beats, outputs stable under stall, error_count=0.
- COUNT_WIDTH=2, send 5 mismatching beats → error_count sticks at 3.
- Assert resetn low mid-stream after tuser 40 → m_tvalid=0 and error_count=0 immediately; resume at tuser 100 → locked, no error.
